// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;
endpackage

// File: rtl/onehot_dec3to8.sv
// Combinational 3-to-8 one-hot decoder: out = 1 << in.
module onehot_dec3to8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   in,
    output logic [NUM_REQ-1:0] out
);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    assign out = ONE << in;
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with grant held until the owner releases.
// Optional forced revocation after TIMEOUT_CYCLES is enabled with `define ARB_TIMEOUT_EN.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   req,
    output logic [7:0]   gnt,
    output logic         gnt_valid,
    output logic [2:0]   gnt_idx,
    output logic         timeout
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("rr_arbiter8: TIMEOUT_CYCLES must be >= 2");
    end

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;
    logic                 new_grant;
    logic                 expire;
    logic [NUM_REQ-1:0]   idx_oh;
    logic [NUM_REQ-1:0]   other;

    // First set bit of r, searching upward from p and wrapping 7 -> 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] cand;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = p + IDX_W'(i);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    onehot_dec3to8 u_dec (
        .in  (idx_q),
        .out (idx_oh)
    );

    assign other = req & ~idx_oh;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every grant; past a release its value is never looked at.
    always_comb begin
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = '0;
        end else if (state_q == ARB_BUSY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        new_grant = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    idx_d     = rr_pick(req, ptr_q);
                    valid_d   = 1'b1;
                    state_d   = ARB_BUSY;
                    new_grant = 1'b1;
                end
            end
            ARB_BUSY: begin
                // A revocation is handled exactly like a release, owner excluded via 'other'.
                if (!req[idx_q] || expire) begin
                    ptr_d     = idx_q + 1'b1;
                    timeout_d = req[idx_q];
                    if (|other) begin
                        idx_d     = rr_pick(other, idx_q + 1'b1);
                        new_grant = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = valid_q ? idx_oh : '0;
    assign gnt_valid = valid_q;
    assign gnt_idx   = idx_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic against a queue-free model.
module tb_rr_arbiter8;
    localparam int TCYC = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       timeout;

    int checks = 0;
    int failures = 0;

    // Reference model state: current owner (-1 = none), next priority, cycles held, revoke flag.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    rr_arbiter8 #(.TIMEOUT_CYCLES(TCYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input logic [7:0] r, input int start);
        for (int i = 0; i < 8; i++) begin
            if (r[(start + i) % 8]) return (start + i) % 8;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] r);
        logic [7:0] rest;
        int w;
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = first_from(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
            end
        end else if (!r[m_owner] || (TO_EN && m_held >= TCYC)) begin
            m_to  = r[m_owner];
            m_ptr = (m_owner + 1) % 8;
            rest  = r;
            rest[m_owner] = 1'b0;
            m_owner = first_from(rest, m_ptr);
            m_held  = 1;
        end else begin
            m_held++;
        end
    endfunction

    function automatic logic [7:0] model_gnt();
        logic [7:0] g;
        g = 8'h00;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_gnt: got %h want 00", gnt);
        end
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got valid=%b timeout=%b want 0/0", gnt_valid, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req = 8'h01;
        @(posedge clk);
        model_step(req);
        #1;
        checks++;
        if (gnt !== 8'h01 || gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_first_grant: got gnt=%h valid=%b idx=%0d want 01/1/0", gnt, gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_rotation();
        int got[$];
        do_reset();
        req = 8'hFF;
        for (int c = 0; c < 40 && got.size() < 9; c++) begin
            @(posedge clk);
            model_step(req);
            #1;
            checks++;
            if (gnt_valid !== 1'b1 || gnt !== model_gnt()) begin
                failures++;
                $display("FAIL rotation_cycle%0d: got gnt=%h valid=%b want %h/1", c, gnt, gnt_valid, model_gnt());
            end
            if (m_held == 1) got.push_back(int'(gnt_idx));
            req = (m_held == 2) ? (8'hFF & ~(8'h01 << m_owner)) : 8'hFF;
        end
        checks++;
        if (got.size() != 9) begin
            failures++;
            $display("FAIL rotation_count: got %0d grants want 9", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] != k % 8) begin
                failures++;
                $display("FAIL rotation_order[%0d]: got %0d want %0d", k, got[k], k % 8);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h20;
        @(posedge clk);
        model_step(req);
        #1;
        req = 8'h03;
        @(posedge clk);
        model_step(req);
        #1;
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL wrap_first: got gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
        end
        req = 8'h02;
        @(posedge clk);
        model_step(req);
        #1;
        checks++;
        if (gnt !== 8'h02 || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_second: got gnt=%h valid=%b want 02/1", gnt, gnt_valid);
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 8'h08;
        @(posedge clk);
        #1;
        req = 8'h09;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
                failures++;
                $display("FAIL no_preempt_hold: got gnt=%h idx=%0d want 08/3", gnt, gnt_idx);
            end
        end
        req = 8'h00;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_preempt_idle: got gnt=%h valid=%b want 00/0", gnt, gnt_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h10;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 8'h10) begin
            failures++;
            $display("FAIL async_pre: got gnt=%h want 10", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL async_clear: got gnt=%h valid=%b idx=%0d want 00/0/0", gnt, gnt_valid, gnt_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req = 8'h30;
        @(posedge clk);
        #1;
        checks++;
        if (gnt_idx !== 3'd4 || gnt !== 8'h10) begin
            failures++;
            $display("FAIL async_restart: got idx=%0d gnt=%h want 4/10", gnt_idx, gnt);
        end
        req = 8'h00;
    endtask

    task automatic test_timeout();
        logic [7:0] exp_g;
        logic       exp_t;
        do_reset();
        req = 8'h04;
`ifdef ARB_TIMEOUT_EN
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            exp_g = (e <= 4) ? 8'h04 : ((e <= 8) ? 8'h20 : 8'h04);
            exp_t = (e == 5 || e == 9);
            checks++;
            if (gnt !== exp_g || timeout !== exp_t) begin
                failures++;
                $display("FAIL timeout_edge%0d: got gnt=%h to=%b want %h/%b", e, gnt, timeout, exp_g, exp_t);
            end
            req = 8'h24;
        end
`else
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            exp_g = 8'h04;
            exp_t = 1'b0;
            checks++;
            if (gnt !== exp_g || timeout !== exp_t) begin
                failures++;
                $display("FAIL timeout_off_edge%0d: got gnt=%h to=%b want %h/%b", e, gnt, timeout, exp_g, exp_t);
            end
            req = 8'h24;
        end
`endif
        req = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0] r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            req = r;
            @(posedge clk);
            model_step(req);
            #1;
            checks++;
            if (gnt !== model_gnt() || gnt_valid !== (m_owner >= 0) || timeout !== m_to) begin
                failures++;
                $display("FAIL random_c%0d: got gnt=%h v=%b to=%b want %h/%b/%b req=%h",
                         c, gnt, gnt_valid, timeout, model_gnt(), (m_owner >= 0), m_to, req);
            end
            if (m_owner >= 0) begin
                checks++;
                if (int'(gnt_idx) != m_owner) begin
                    failures++;
                    $display("FAIL random_idx_c%0d: got %0d want %0d", c, gnt_idx, m_owner);
                end
            end
            checks++;
            if ($countones(gnt) > 1) begin
                failures++;
                $display("FAIL random_onehot_c%0d: got %h want at most one bit", c, gnt);
            end
        end
        req = 8'h00;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_wrap();
        test_no_preempt();
        test_async_reset();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
